// File: rtl/rr_arb4_b4_pkg.sv
// Shared definitions for the rr_arb4_b4 round-robin arbiter: requester count,
// select width, the pointer reset value and a one-hot decode helper.
package rr_arb4_b4_pkg;

    localparam int unsigned ARB_N       = 4;
    localparam int unsigned ARB_SW      = 2;
    localparam logic [1:0]  ARB_PTR_RST = 2'b11;

    function automatic logic [ARB_N-1:0] onehot4(input logic [ARB_SW-1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arb4_b4_pick4.sv
// Combinational round-robin picker: scans ptr+1 .. ptr+4 (mod 4) and returns
// the first requesting index plus an any-request flag.
module rr_pick4
    import rr_arb4_b4_pkg::*;
(
    input  logic [ARB_N-1:0]  req,
    input  logic [ARB_SW-1:0] ptr,
    output logic [ARB_SW-1:0] gnt,
    output logic              any
);

    logic [ARB_SW-1:0] gnt_s;
    logic              found_s;

    // Rotating priority search; the last slot (k=4) wraps back to ptr itself.
    always_comb begin
        gnt_s   = ptr;
        found_s = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found_s && req[ptr + 2'(k)]) begin
                gnt_s   = ptr + 2'(k);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt = gnt_s;
    assign any = found_s;

endmodule

// File: rtl/rr_arb4_b4.sv
// Four-requester round-robin arbiter with a registered valid/ready output stage.
// Optional burst lock on the current pointer when ARB_LOCK_EN is defined.
module rr_arb4_b4
    import rr_arb4_b4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     REQ,
    input  logic [W-1:0]         I0,
    input  logic [W-1:0]         I1,
    input  logic [W-1:0]         I2,
    input  logic [W-1:0]         I3,
    output logic [ARB_N-1:0]     ACK,
    output logic [ARB_SW-1:0]    S,
    output logic [W-1:0]         O,
    output logic                 O_VALID,
    input  logic                 O_READY
`ifdef ARB_LOCK_EN
    ,
    input  logic [ARB_N-1:0]     LOCK
`endif
);

    logic [ARB_SW-1:0] ptr_r;
    logic [ARB_SW-1:0] s_r;
    logic [W-1:0]      o_r;
    logic              o_valid_r;

    logic              free_s;
    logic [ARB_SW-1:0] pick_gnt_s;
    logic              pick_any_s;
    logic              lock_hit_s;
    logic [ARB_SW-1:0] win_idx_s;
    logic              win_s;
    logic [W-1:0]      win_data_s;

    rr_pick4 u_pick (
        .req (REQ),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .any (pick_any_s)
    );

`ifdef ARB_LOCK_EN
    assign lock_hit_s = REQ[ptr_r] & LOCK[ptr_r];
`else
    assign lock_hit_s = 1'b0;
`endif

    assign free_s = !o_valid_r | O_READY;

    // Winner selection; a lock hit implies any-request, so win only needs pick_any_s.
    always_comb begin
        win_idx_s = lock_hit_s ? ptr_r : pick_gnt_s;
        win_s     = rst_n & free_s & pick_any_s;
        case (win_idx_s)
            2'd0:    win_data_s = I0;
            2'd1:    win_data_s = I1;
            2'd2:    win_data_s = I2;
            2'd3:    win_data_s = I3;
            default: win_data_s = I0;
        endcase
    end

    assign ACK = win_s ? onehot4(win_idx_s) : 4'b0000;

    // Output stage: capture on win, drain when consumed with nothing new, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_r       <= '0;
            o_valid_r <= 1'b0;
            s_r       <= ARB_PTR_RST;
            ptr_r     <= ARB_PTR_RST;
        end else if (win_s) begin
            o_r       <= win_data_s;
            o_valid_r <= 1'b1;
            s_r       <= win_idx_s;
            ptr_r     <= win_idx_s;
        end else if (free_s) begin
            o_valid_r <= 1'b0;
        end else begin
            o_valid_r <= o_valid_r;
        end
    end

    assign S       = s_r;
    assign O       = o_r;
    assign O_VALID = o_valid_r;

endmodule

// File: tb/tb_rr_arb4_b4.sv
// Self-checking bench for rr_arb4_b4: directed steps then random traffic, all
// compared against a round-robin reference model kept in the bench.
module tb_rr_arb4_b4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] REQ;
    logic [3:0] LOCK;
    logic [3:0] din [4];
    logic [3:0] I0, I1, I2, I3;
    logic [3:0] ACK;
    logic [1:0] S;
    logic [3:0] O;
    logic       O_VALID;
    logic       O_READY;

    int n_assert = 0;
    int n_fail   = 0;

    int         m_ptr;
    int         m_s;
    logic [3:0] m_o;
    logic       m_valid;

`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    assign I0 = din[0];
    assign I1 = din[1];
    assign I2 = din[2];
    assign I3 = din[3];

    always #5 clk = ~clk;

    rr_arb4_b4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .REQ     (REQ),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .ACK     (ACK),
        .S       (S),
        .O       (O),
        .O_VALID (O_VALID),
        .O_READY (O_READY)
`ifdef ARB_LOCK_EN
        ,
        .LOCK    (LOCK)
`endif
    );

    function automatic int ref_pick(int p, logic [3:0] r, logic [3:0] l);
        if (LOCK_EN && r[p] && l[p]) return p;
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 3;
        m_s     = 3;
        m_o     = 4'h0;
        m_valid = 1'b0;
    endtask

    // One clock: drive inputs, check ACK before the edge, check outputs after it.
    task automatic step(input logic rst_v, input logic [3:0] req_v,
                        input logic [3:0] lock_v, input logic rdy_v);
        int w;
        logic [3:0] exp_ack;
        rst_n   = rst_v;
        REQ     = req_v;
        LOCK    = lock_v;
        O_READY = rdy_v;
        #1;
        w = -1;
        if (rst_v && (!m_valid || rdy_v)) w = ref_pick(m_ptr, req_v, lock_v);
        exp_ack = (w >= 0) ? 4'(1 << w) : 4'b0000;
        chk("ack", {4'h0, ACK}, {4'h0, exp_ack});
        @(posedge clk);
        #1;
        if (!rst_v) begin
            model_reset();
        end else if (w >= 0) begin
            m_o     = din[w];
            m_valid = 1'b1;
            m_s     = w;
            m_ptr   = w;
        end else if (!m_valid || rdy_v) begin
            m_valid = 1'b0;
        end
        chk("o",       {4'h0, O},       {4'h0, m_o});
        chk("s",       {6'h0, S},       8'(m_s));
        chk("o_valid", {7'h0, O_VALID}, {7'h0, m_valid});
    endtask

    initial begin
        model_reset();
        din[0] = 4'h1; din[1] = 4'h2; din[2] = 4'h3; din[3] = 4'h4;
        rst_n = 1'b0; REQ = 4'h0; LOCK = 4'h0; O_READY = 1'b1;
        @(posedge clk);
        #1;

        // Reset with all requests pending.
        step(1'b0, 4'hF, 4'h0, 1'b1);
        step(1'b0, 4'hF, 4'h0, 1'b1);
        chk("rst_s_const", {6'h0, S}, 8'h03);

        // All request, continuous ready: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) step(1'b1, 4'hF, 4'h0, 1'b1);
        chk("rr_wrap_o", {4'h0, O}, 8'h01);

        // Backpressure: capture I2=A, hold three cycles, then release.
        din[2] = 4'hA;
        step(1'b1, 4'b0100, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 4'h0, 1'b0);
        chk("bp_hold_o", {4'h0, O}, 8'h0A);
        step(1'b1, 4'hF, 4'h0, 1'b1);
        chk("bp_release_s", {6'h0, S}, 8'h03);

        // Sparse single request, then drain.
        din[1] = 4'h5;
        step(1'b1, 4'b0010, 4'h0, 1'b1);
        step(1'b1, 4'b0000, 4'h0, 1'b1);
        chk("sparse_drain_o", {4'h0, O}, 8'h05);

        // Mid-operation reset while stalled.
        step(1'b1, 4'b1000, 4'h0, 1'b1);
        step(1'b1, 4'hF, 4'h0, 1'b0);
        step(1'b0, 4'hF, 4'h0, 1'b0);
        step(1'b1, 4'b0110, 4'h0, 1'b1);
        chk("post_rst_s", {6'h0, S}, 8'h01);

`ifdef ARB_LOCK_EN
        // Lock burst on requester 2, then release.
        step(1'b1, 4'b0100, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 4'b0100, 1'b1);
        chk("lock_s", {6'h0, S}, 8'h02);
        step(1'b1, 4'hF, 4'b0000, 1'b1);
        chk("unlock_s", {6'h0, S}, 8'h03);
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 500; n++) begin
            for (int j = 0; j < 4; j++) din[j] = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 49) != 0),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
